// File: rtl/axis_downsizer.sv
// axis_downsizer: splits each wide AXI-Stream beat into RATIO narrow segments, LSB segment first.
// Define AXIS_DOWNSIZER_KEEP_EN to end a tlast beat after its last segment with any keep bit set.
module axis_downsizer #(
  parameter int S_DATA_WIDTH = 32,
  parameter int M_DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  localparam int RATIO = S_DATA_WIDTH / M_DATA_WIDTH,
  localparam int S_KEEP = S_DATA_WIDTH / 8,
  localparam int M_KEEP = M_DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [S_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [S_KEEP-1:0]       s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic [M_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [M_KEEP-1:0]       m_axis_tkeep,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser
);
  localparam int SEG_W = $clog2(RATIO);
  logic [S_DATA_WIDTH-1:0] r_data;
  logic [S_KEEP-1:0]       r_keep;
  logic                    r_last;
  logic [USER_WIDTH-1:0]   r_user;
  logic                    r_valid;
  logic [SEG_W-1:0]        r_seg;
  logic                    w_last_seg;
  logic                    w_final;
  logic                    w_s_hs;
  logic                    w_m_hs;
  assign w_last_seg = r_seg == SEG_W'(RATIO - 1);
`ifdef AXIS_DOWNSIZER_KEEP_EN
  logic [S_KEEP-1:0] w_hi_keep;
  // keep bits belonging to segments above the current one
  assign w_hi_keep = r_keep >> ((32'(r_seg) + 32'd1) * M_KEEP);
  assign w_final = w_last_seg || (r_last && w_hi_keep == '0);
`else
  assign w_final = w_last_seg;
`endif
  assign s_axis_tready = !r_valid || (m_axis_tready && w_final);
  assign w_s_hs = s_axis_tvalid && s_axis_tready;
  assign w_m_hs = r_valid && m_axis_tready;
  assign m_axis_tvalid = r_valid;
  assign m_axis_tdata = r_data[r_seg*M_DATA_WIDTH +: M_DATA_WIDTH];
  assign m_axis_tkeep = r_keep[r_seg*M_KEEP +: M_KEEP];
  assign m_axis_tlast = r_last && w_final;
  assign m_axis_tuser = r_user;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data <= '0;
      r_keep <= '0;
      r_last <= 1'b0;
      r_user <= '0;
      r_valid <= 1'b0;
      r_seg <= '0;
    end else if (w_s_hs) begin
      r_data <= s_axis_tdata;
      r_keep <= s_axis_tkeep;
      r_last <= s_axis_tlast;
      r_user <= s_axis_tuser;
      r_valid <= 1'b1;
      r_seg <= '0;
    end else if (w_m_hs) begin
      r_valid <= !w_final;
      r_seg <= w_final ? '0 : r_seg + 1'b1;
    end
  end
endmodule
